bitcore_seq: RTL and testbench

- Parametrised multi-cycle successor to the 1-bit XOR/JMP datapath.
- Generalises the register to DATA_W bits and the program counter to PC_W bits.
- Adds load-immediate, conditional jump, halt detection and a fetch handshake to an external instruction memory.
- Sits between the instruction ROM/RAM and any observer of reg_out and pc_out.

---
 rtl/bitcore_seq.sv | 123 ++++++++++++
 tb/tb_bitcore_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bitcore_seq.sv
// Multi-cycle accumulator core: fetches {op, imm} words from external memory and executes XOR/LDI/JMP/JNZ.
// Optional single-step gating is enabled with the BITCORE_SEQ_STEP_EN macro.
module bitcore_seq #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned PC_W     = 3,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef BITCORE_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W+1:0] imem_rdata,
  output logic [DATA_W-1:0] reg_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              retire,
  output logic              halted
);

  localparam logic [PC_W-1:0] LP_RESET_PC = RESET_PC[PC_W-1:0];

`ifdef BITCORE_SEQ_STEP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`endif

  state_t              r_state;
  logic [DATA_W+1:0]   r_instr;
  logic [DATA_W-1:0]   r_reg;
  logic [PC_W-1:0]     r_pc;
  logic                r_req;
  logic                r_retire;
  logic                r_halted;

  logic [1:0]          w_op;
  logic [DATA_W-1:0]   w_imm;
  logic [PC_W-1:0]     w_tgt;
  logic [PC_W-1:0]     w_pc_inc;

  assign w_op     = r_instr[DATA_W+1:DATA_W];
  assign w_imm    = r_instr[DATA_W-1:0];
  assign w_tgt    = w_imm[PC_W-1:0];
  assign w_pc_inc = r_pc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_reg    <= '0;
      r_pc     <= LP_RESET_PC;
      r_req    <= 1'b0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_valid) begin
            r_instr  <= imem_rdata;
            r_state  <= S_EXEC;
            r_req    <= 1'b0;
            r_retire <= 1'b1;
          end
        end
        S_EXEC: begin
          r_retire <= 1'b0;
          case (w_op)
            2'b00: begin
              r_reg <= r_reg ^ w_imm;
              r_pc  <= w_pc_inc;
            end
            2'b01: begin
              r_reg <= w_imm;
              r_pc  <= w_pc_inc;
            end
            2'b10:   r_pc <= w_tgt;
            default: r_pc <= (r_reg != '0) ? w_tgt : w_pc_inc;
          endcase
          // Only an unconditional self-jump halts; JNZ-to-self keeps fetching.
          if (w_op == 2'b10 && w_tgt == r_pc) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
`ifdef BITCORE_SEQ_STEP_EN
            r_state <= S_WAIT;
`else
            r_state <= S_FETCH;
            r_req   <= 1'b1;
`endif
          end
        end
        S_HALT: r_state <= S_HALT;
`ifdef BITCORE_SEQ_STEP_EN
        S_WAIT: begin
          if (step) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign reg_out   = r_reg;
  assign pc_out    = r_pc;
  assign retire    = r_retire;
  assign halted    = r_halted;

endmodule

// File: tb/tb_bitcore_seq.sv
// Directed bench for bitcore_seq: memory responder, ISA model and expected-result queue.
module tb_bitcore_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_valid = 1'b0;
  logic [5:0] imem_rdata = '0;
  logic       imem_req;
  logic [2:0] imem_addr;
  logic [3:0] reg_out;
  logic [2:0] pc_out;
  logic       retire;
  logic       halted;

  bitcore_seq #(.DATA_W(4), .PC_W(3), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef BITCORE_SEQ_STEP_EN
    .step       (1'b1),
`endif
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .reg_out    (reg_out),
    .pc_out     (pc_out),
    .retire     (retire),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [3:0] r;
    logic [2:0] p;
    logic       h;
  } exp_t;

  exp_t       q[$];
  logic [5:0] mem[8];
  logic [3:0] m_reg;
  logic [2:0] m_pc;
  logic       m_halt;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_exec(input logic [5:0] ins);
    logic [2:0] tgt;
    tgt = ins[2:0];
    case (ins[5:4])
      2'b00: begin m_reg = m_reg ^ ins[3:0]; m_pc = m_pc + 3'd1; end
      2'b01: begin m_reg = ins[3:0];         m_pc = m_pc + 3'd1; end
      2'b10: begin
        if (tgt == m_pc) m_halt = 1'b1;
        else m_pc = tgt;
      end
      default: m_pc = (m_reg != 4'd0) ? tgt : m_pc + 3'd1;
    endcase
  endtask

  // Serve one fetch with the given number of wait cycles; returns the cycle retire was seen.
  task automatic run_instr(input int waits, output int ret_cyc);
    int n;
    logic [5:0] ins;
    exp_t e;
    n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_up", imem_req, 1);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", imem_req, 1);
      chk("addr_wait", imem_addr, m_pc);
      chk("no_retire_wait", retire, 0);
      @(negedge clk);
    end
    chk("addr", imem_addr, m_pc);
    ins = mem[m_pc];
    imem_rdata = ins;
    imem_valid = 1'b1;
    model_exec(ins);
    q.push_back('{r: m_reg, p: m_pc, h: m_halt});
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 6'h3F;
    chk("retire", retire, 1);
    chk("req_exec", imem_req, 0);
    ret_cyc = cyc;
    @(negedge clk);
    e = q.pop_front();
    chk("reg", reg_out, e.r);
    chk("pc", pc_out, e.p);
    chk("halted", halted, e.h);
    chk("retire_low", retire, 0);
  endtask

  initial begin
    int c1, c2;
    mem[0] = 6'b01_1010; mem[1] = 6'b00_0110; mem[2] = 6'b11_0101; mem[3] = 6'b10_0111;
    mem[4] = 6'b10_0100; mem[5] = 6'b01_0000; mem[6] = 6'b10_0010; mem[7] = 6'b00_0001;
    m_reg = '0; m_pc = '0; m_halt = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_reg", reg_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);

    run_instr(3, c1);                 // LDI A with three wait cycles
    chk("ldi_reg", reg_out, 4'hA);
    run_instr(0, c2);                 // XOR 6 -> C
    chk("xor_reg", reg_out, 4'hC);
    chk("xor_pc", pc_out, 2);
    chk("spacing", c2 - c1, 2);
    run_instr(0, c1);                 // JNZ 5, reg nonzero
    chk("jnz_taken", pc_out, 5);
    run_instr(0, c1);                 // LDI 0
    run_instr(0, c1);                 // JMP 2
    run_instr(0, c1);                 // JNZ 5, reg zero
    chk("jnz_fall", pc_out, 3);
    run_instr(0, c1);                 // JMP 7
    run_instr(0, c1);                 // XOR 1 at pc 7 wraps
    chk("wrap_pc", pc_out, 0);
    chk("wrap_reg", reg_out, 4'h1);
    mem[0] = 6'b10_0100;
    run_instr(0, c1);                 // JMP 4 (not a halt)
    chk("jmp_nohalt", halted, 0);
    run_instr(0, c1);                 // JMP 4 at pc 4 -> halt
    chk("halt_flag", halted, 1);

    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'b1;
      imem_rdata = 6'($urandom_range(0, 63));
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_hold", halted, 1);
      chk("halt_retire", retire, 0);
      chk("halt_pc", pc_out, 4);
      chk("halt_reg", reg_out, 4'h1);
    end
    imem_valid = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_pc", pc_out, 0);
    chk("rst2_reg", reg_out, 0);
    mem[0] = 6'b01_1010;
    m_reg = '0; m_pc = '0; m_halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    run_instr(0, c1);
    run_instr(0, c2);
    chk("spacing2", c2 - c1, 2);
    chk("restart_reg", reg_out, 4'hC);

    // Reset in the middle of a pending fetch
    chk("midfetch_req", imem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 0);
    chk("midrst_pc", pc_out, 0);
    chk("midrst_reg", reg_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_refetch", imem_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
